// File: rtl/spi_slave_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_slave_engine_pkg                                   |
// | Description : Shared constants, state encoding and bit-order helpers |
// |               for the SPI slave engine.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package spi_slave_engine_pkg;

  localparam int c_SPI_DW = 8;
  localparam int c_CNT_W  = 3;

  // Controller state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_SHIFT = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_LOAD  = c_ST_LOAD,
    ST_SHIFT = c_ST_SHIFT,
    ST_DONE  = c_ST_DONE
  } spi_state_t;

  // Byte sent when the master clocks a transfer with no byte queued
  localparam logic [c_SPI_DW-1:0] c_TX_EMPTY_FILL = 8'hFF;

  // Bit currently at the output end of the shifter for the chosen order
  function automatic logic out_bit(input logic [c_SPI_DW-1:0] b, input logic lsbfe);
    return lsbfe ? b[0] : b[c_SPI_DW-1];
  endfunction

  // Shift one received bit in at the far end; the next TX bit moves to the output end
  function automatic logic [c_SPI_DW-1:0] shift_in(input logic [c_SPI_DW-1:0] b,
                                                   input logic lsbfe,
                                                   input logic d);
    return lsbfe ? {d, b[c_SPI_DW-1:1]} : {b[c_SPI_DW-2:0], d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_engine_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_sync_edge                                          |
// | Description : Multi-flop synchronizers for the SPI pins plus edge    |
// |               detection on the synchronized sck, classified as       |
// |               leading/trailing relative to the idle clock level.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_sync_edge
  import spi_slave_engine_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cpol,
  input  logic i_sck,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_ss_n,
  output logic o_mosi,
  output logic o_lead,
  output logic o_trail
);

  logic [SYNC_STAGES-1:0] r_sck_q;
  logic [SYNC_STAGES-1:0] r_ss_n_q;
  logic [SYNC_STAGES-1:0] r_mosi_q;
  logic                   r_sck_d;
  logic                   w_sck_s;
  logic                   w_rise;
  logic                   w_fall;

  // Synchronizer chains (idle levels: sck low, ss_n high, mosi low) and sck history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_q  <= '0;
      r_ss_n_q <= '1;
      r_mosi_q <= '0;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_q  <= {r_sck_q[SYNC_STAGES-2:0], i_sck};
      r_ss_n_q <= {r_ss_n_q[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_q <= {r_mosi_q[SYNC_STAGES-2:0], i_mosi};
      r_sck_d  <= r_sck_q[SYNC_STAGES-1];
    end
  end

  assign w_sck_s = r_sck_q[SYNC_STAGES-1];
  assign w_rise  = w_sck_s & ~r_sck_d;
  assign w_fall  = ~w_sck_s & r_sck_d;

  assign o_ss_n  = r_ss_n_q[SYNC_STAGES-1];
  assign o_mosi  = r_mosi_q[SYNC_STAGES-1];
  // Leading edge leaves the idle (CPOL) level
  assign o_lead  = i_cpol ? w_fall : w_rise;
  assign o_trail = i_cpol ? w_rise : w_fall;

endmodule
`default_nettype wire

// File: rtl/spi_slave_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_slave_engine                                       |
// | Description : 8-bit SPI slave: IDLE/LOAD/SHIFT/DONE controller, one  |
// |               shared TX/RX shifter, single-entry TX buffer, sticky   |
// |               SPIF/OVR flags. All pins oversampled by clk.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_slave_engine
  import spi_slave_engine_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SPE,
  input  logic                CPOL,
  input  logic                CPHA,
  input  logic                LSBFE,
  input  logic                sck_in,
  input  logic                ss_n_in,
  input  logic                mosi_in,
  output logic                miso_out,
  output logic                miso_oe,
  input  logic [c_SPI_DW-1:0] tx_data,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic [c_SPI_DW-1:0] rx_data,
  output logic                SPIF,
  output logic                OVR,
  input  logic                spif_clr,
  output logic                busy
);

  spi_state_t          r_state;
  spi_state_t          w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_SPI_DW-1:0] r_sh;
  logic [c_SPI_DW-1:0] r_txbuf;
  logic                r_tx_full;
  logic [c_SPI_DW-1:0] r_rx;
  logic                r_spif;
  logic                r_ovr;
  logic                r_miso;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_lsbfe;

  logic                w_ss_n_s;
  logic                w_mosi_s;
  logic                w_lead;
  logic                w_trail;
  logic                w_sample;
  logic                w_shift;
  logic                w_abort;
  logic                w_done_set;
  logic                w_tx_take;
  logic [c_SPI_DW-1:0] w_load_val;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_cpol  (r_cpol),
    .i_sck   (sck_in),
    .i_ss_n  (ss_n_in),
    .i_mosi  (mosi_in),
    .o_ss_n  (w_ss_n_s),
    .o_mosi  (w_mosi_s),
    .o_lead  (w_lead),
    .o_trail (w_trail)
  );

  assign w_sample   = r_cpha ? w_trail : w_lead;
  assign w_shift    = r_cpha ? w_lead  : w_trail;
  assign w_abort    = !SPE || w_ss_n_s;
  assign w_load_val = r_tx_full ? r_txbuf : c_TX_EMPTY_FILL;
  // A completed byte is only posted while the engine is enabled
  assign w_done_set = (r_state == ST_DONE) && SPE;
  // The buffer slot being vacated by LOAD may be refilled in the same cycle
  assign w_tx_take  = tx_load && (!r_tx_full || r_state == ST_LOAD);

  // Next-state logic for the transfer controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (SPE && !w_ss_n_s) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = w_abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (w_abort)                  w_state_nxt = ST_IDLE;
        else if (w_sample && &r_cnt)  w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = w_abort ? ST_IDLE : ST_LOAD;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Mode capture, bit counter and shifter/output bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsbfe <= 1'b0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_miso  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_cpol  <= CPOL;
        r_cpha  <= CPHA;
        r_lsbfe <= LSBFE;
      end
      if (r_state == ST_LOAD || w_state_nxt == ST_IDLE)
        r_cnt <= '0;
      else if (r_state == ST_SHIFT && w_sample)
        r_cnt <= r_cnt + 3'd1;
      if (r_state == ST_LOAD) begin
        r_sh   <= w_load_val;
        r_miso <= out_bit(w_load_val, r_lsbfe);
      end else if (r_state == ST_SHIFT) begin
        if (w_shift)  r_miso <= out_bit(r_sh, r_lsbfe);
        if (w_sample) r_sh   <= shift_in(r_sh, r_lsbfe, w_mosi_s);
      end
    end
  end

  // Single-entry transmit buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txbuf   <= '0;
      r_tx_full <= 1'b0;
    end else if (w_tx_take) begin
      r_txbuf   <= tx_data;
      r_tx_full <= 1'b1;
    end else if (r_state == ST_LOAD) begin
      r_tx_full <= 1'b0;
    end
  end

  // Receive data and sticky flags; a DONE post beats a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx   <= '0;
      r_spif <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (w_done_set) begin
      if (!r_spif) begin
        r_rx   <= r_sh;
        r_spif <= 1'b1;
      end else begin
        r_ovr  <= 1'b1;
      end
    end else if (spif_clr) begin
      r_spif <= 1'b0;
      r_ovr  <= 1'b0;
    end
  end

  // In LOAD the first bit is driven straight from the value being loaded
  assign miso_oe  = SPE && !w_ss_n_s && (r_state != ST_IDLE);
  assign miso_out = miso_oe &&
                    ((r_state == ST_LOAD) ? out_bit(w_load_val, r_lsbfe) : r_miso);
  assign busy     = (r_state != ST_IDLE);
  assign tx_ready = !r_tx_full;
  assign rx_data  = r_rx;
  assign SPIF     = r_spif;
  assign OVR      = r_ovr;

endmodule
`default_nettype wire

// File: doc/spi_slave_engine.md
SPI_SLAVE_ENGINE -- requirements
Module: spi_slave_engine

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth on sck_in/ss_n_in/mosi_in (legal 2..3).
REQ-002 clk  in  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 SPE  in  1  SPI enable; 0 forces IDLE.
REQ-005 CPOL, CPHA, LSBFE  in  1 each  clock polarity, clock phase, LSB-first select; sampled only in IDLE.
REQ-006 sck_in, ss_n_in, mosi_in  in  1 each  external master pins, asynchronous to clk.
REQ-007 miso_out  out  1  serial data to master; miso_oe  out  1  output enable, 1 only when selected and SPE=1.
REQ-008 tx_data  in  8, tx_load  in  1, tx_ready  out  1  transmit-buffer write handshake.
REQ-009 rx_data  out  8  last received byte; SPIF  out  1  sticky byte-complete flag; OVR  out  1  sticky overrun flag.
REQ-010 spif_clr  in  1  one-cycle pulse clearing SPIF and OVR; busy  out  1  high outside IDLE.

Function
REQ-011 sck_in, ss_n_in and mosi_in SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized sck.
REQ-012 Leading edge = sck leaving the CPOL level; sample edge = leading if CPHA=0, trailing if CPHA=1; the other edge is the shift edge.
REQ-013 States: IDLE, LOAD, SHIFT, DONE; 2-bit encoding from the shared package.
REQ-014 IDLE->LOAD when SPE=1 and synchronized ss_n=0; LOAD->SHIFT after exactly one cycle; SHIFT->DONE on the 8th sample edge; DONE->LOAD if ss_n=0, else DONE->IDLE.
REQ-015 LOAD SHALL copy the tx buffer into the shifter and mark it empty; if empty, the shifter SHALL load 8'hFF.
REQ-016 CPHA=0: first bit SHALL be on miso_out from LOAD onward; subsequent bits advance on shift edges.
REQ-017 CPHA=1: each bit, including the first, advances on the leading (shift) edge.
REQ-018 Bit order SHALL be MSB-first when LSBFE=0, LSB-first when LSBFE=1, identical for TX and RX.
REQ-019 A 3-bit counter SHALL count sample edges in SHIFT, clear in LOAD, and wrap 7->0 at DONE entry.
REQ-020 In DONE: if SPIF=0, rx_data<=shifter and SPIF<=1; if SPIF=1, rx_data SHALL be unchanged and OVR<=1.
REQ-021 spif_clr coincident with a DONE set: set SHALL win; spif_clr in any other cycle clears SPIF and OVR next edge.
REQ-022 tx_ready=1 iff tx buffer empty; tx_load with tx_ready=1 captures tx_data next edge; tx_load with tx_ready=0 SHALL be ignored.
REQ-023 tx_load coincident with LOAD consumption: LOAD SHALL take the old buffer content (or 8'hFF), the new byte SHALL be captured.
REQ-024 Synchronized ss_n rising in LOAD/SHIFT SHALL abort to IDLE next edge: counter cleared, no SPIF/OVR/rx_data change, partial byte discarded.
REQ-025 SPE=0 in any state SHALL force IDLE next edge with the same abort semantics; miso_oe=0 combinationally.
REQ-026 miso_out SHALL be 0 when miso_oe=0.
REQ-027 External master SHALL keep sck period >= 4 clk periods and sck high/low each >= 2 clk; behaviour beyond this is undefined.

Reset
REQ-028 rst=0 SHALL asynchronously force: state IDLE, counter 0, shifter 0, tx buffer empty (tx_ready=1), rx_data 8'h00, SPIF 0, OVR 0, busy 0, miso_oe 0, miso_out 0, synchronizers to idle levels (sck=CPOL-independent 0, ss_n=1, mosi=0).
REQ-029 Reset mid-byte SHALL discard the transfer; release requires a fresh ss_n falling edge to start.

Structure
REQ-030 State encoding localparams and the SPI data width (8) SHALL live in the shared SPI package with the controller's state constants.
REQ-031 A sub-module spi_sync_edge (synchronizer + rise/fall/lead/trail detect for sck, parameterised by SYNC_STAGES) SHALL be instantiated once.

Verification
REQ-032 CPOL=0,CPHA=0,LSBFE=0, tx 8'hA5 loaded, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; SPIF=1.
REQ-033 CPOL=1,CPHA=1,LSBFE=1, tx 8'h81, master sends 8'h01 -> miso LSB-first 1,0,0,0,0,0,0,1; rx_data=8'h01.
REQ-034 Two back-to-back bytes 8'h11, 8'h22 with ss_n low, SPIF not cleared -> rx_data=8'h11, SPIF=1, OVR=1.
REQ-035 No tx_load before transfer -> miso shifts 8'hFF; tx_ready stays 1.
REQ-036 ss_n raised after 5 bits -> busy=0 within SYNC_STAGES+2 cycles, SPIF=0, rx_data unchanged; next full byte 8'h5A received correctly.
REQ-037 rst low mid-byte then spif_clr coincident with next DONE -> all outputs at reset values; SPIF ends 1.
